// File: rtl/iicmb_wb_regblock_if.sv
// Wishbone classic slave bus between the host (master) and the register block.
interface iicmb_wb_regblock_if;
    logic       cyc_i;
    logic       stb_i;
    logic       we_i;
    logic [1:0] adr_i;
    logic [7:0] dat_i;
    logic [7:0] dat_o;
    logic       ack_o;

    modport master (output cyc_i, stb_i, we_i, adr_i, dat_i, input dat_o, ack_o);
    modport slave  (input cyc_i, stb_i, we_i, adr_i, dat_i, output dat_o, ack_o);
endinterface

// File: rtl/iicmb_wb_regblock.sv
// Wishbone register block of the I2C multi-bus controller: CSR/DPR/CMDR/FSMR,
// command handoff to the byte engine, completion status capture and interrupt.
module iicmb_wb_regblock #(
    parameter int NUM_BUSES = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    iicmb_wb_regblock_if.slave   wb,
    output logic                 irq,
    output logic                 en_o,
    output logic                 cmd_valid_o,
    output logic [2:0]           cmd_code_o,
    output logic [7:0]           cmd_data_o,
    input  logic                 cmd_ready_i,
    input  logic                 rsp_valid_i,
    input  logic [1:0]           rsp_code_i,
    input  logic [7:0]           rsp_data_i,
    input  logic                 bus_busy_i,
    input  logic                 bus_captured_i,
    input  logic [7:0]           fsm_state_i
);

    localparam logic [7:0] NUM_BUSES_B = 8'(NUM_BUSES);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t     state_q, state_d;
    logic       ack_q;
    logic [7:0] dat_q;
    logic       e_q, ie_q, pending_q;
    logic [3:0] bus_id_q;
    logic [7:0] tx_q, rx_q;
    logic [3:0] status_q;
    logic [2:0] code_q;
    logic [7:0] data_q;
    logic [7:0] rd_data;

    logic access, wr, rd;
    logic csr_wr, dpr_wr, cmdr_wr, cmdr_rd;
    logic e_clear, cmd_accept, cmd_bad, rsp_take;

    // A strobe is only sampled while ack is low, giving one access per two cycles.
    assign access     = wb.cyc_i & wb.stb_i & ~ack_q;
    assign wr         = access & wb.we_i;
    assign rd         = access & ~wb.we_i;
    assign csr_wr     = wr & (wb.adr_i == 2'd0);
    assign dpr_wr     = wr & (wb.adr_i == 2'd1);
    assign cmdr_wr    = wr & (wb.adr_i == 2'd2);
    assign cmdr_rd    = rd & (wb.adr_i == 2'd2);
    assign e_clear    = csr_wr & e_q & ~wb.dat_i[7];
    assign cmd_accept = cmdr_wr & e_q & (state_q == ST_IDLE);
    assign cmd_bad    = (wb.dat_i[2:0] == 3'd7) |
                        ((wb.dat_i[2:0] == 3'd6) & (tx_q >= NUM_BUSES_B));
    assign rsp_take   = (state_q == ST_WAIT) & rsp_valid_i;

    assign wb.ack_o    = ack_q;
    assign wb.dat_o    = dat_q;
    assign en_o        = e_q;
    assign irq         = pending_q & ie_q & e_q;
    assign cmd_valid_o = (state_q == ST_ISSUE);
    assign cmd_code_o  = code_q;
    assign cmd_data_o  = data_q;

    always_comb begin
        rd_data = 8'h00;
        case (wb.adr_i)
            2'd0: rd_data = {e_q, ie_q, bus_busy_i, bus_captured_i, bus_id_q};
            2'd1: rd_data = rx_q;
            2'd2: rd_data = {status_q, 1'b0, code_q};
            2'd3: rd_data = fsm_state_i;
            default: rd_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_accept && !cmd_bad) state_d = ST_ISSUE;
            ST_ISSUE: if (cmd_ready_i)            state_d = ST_WAIT;
            ST_WAIT:  if (rsp_valid_i)            state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
        // Disabling the core abandons any command in progress.
        if (e_clear) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            dat_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            ack_q   <= access;
            if (rd) dat_q <= rd_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            e_q       <= 1'b0;
            ie_q      <= 1'b0;
            pending_q <= 1'b0;
            bus_id_q  <= 4'd0;
            tx_q      <= 8'h00;
            rx_q      <= 8'h00;
            status_q  <= 4'b1000;
            code_q    <= 3'd0;
            data_q    <= 8'h00;
        end else begin
            if (csr_wr) begin
                e_q  <= wb.dat_i[7];
                ie_q <= wb.dat_i[6];
            end
            if (dpr_wr && state_q == ST_IDLE) tx_q <= wb.dat_i;
            if (cmdr_rd) pending_q <= 1'b0;
            if (cmd_accept) begin
                code_q   <= wb.dat_i[2:0];
                data_q   <= tx_q;
                status_q <= cmd_bad ? 4'b0001 : 4'b0000;
                if (cmd_bad) pending_q <= 1'b1;
            end
            // A completion arriving with a CMDR read still sets pending.
            if (rsp_take) begin
                status_q  <= status_q | (4'b1000 >> rsp_code_i);
                pending_q <= 1'b1;
                if (rsp_code_i == 2'd0 && code_q[2:1] == 2'b01) rx_q <= rsp_data_i;
                if (rsp_code_i == 2'd0 && code_q == 3'd6) bus_id_q <= data_q[3:0];
            end
            if (e_clear) begin
                status_q  <= 4'b1000;
                code_q    <= 3'd0;
                pending_q <= 1'b0;
                tx_q      <= 8'h00;
                rx_q      <= 8'h00;
            end
        end
    end

endmodule

// File: doc/iicmb_wb_regblock.md
# iicmb_wb_regblock

Wishbone-side register block of the I2C multiple-bus controller. It decodes 8-bit Wishbone classic slave cycles into four registers: CSR, DPR, CMDR and FSMR. Software commands are forwarded to the downstream byte-level command engine through a valid/ready handshake. Engine responses are captured as CMDR status, and an interrupt is raised when a command completes. It is the block the `wb_pkg` agent drives and monitors directly.

## Interface
- NUM_BUSES, 16: number of I2C buses; 1..16; bus IDs at or above this value are rejected.
- clk_i  in  1  system clock, all logic on the rising edge
- rst_i  in  1  asynchronous, active-low reset
- cyc_i, stb_i, we_i  in  1 each  Wishbone cycle, strobe, write enable
- adr_i  in  2  register select: 0 CSR, 1 DPR, 2 CMDR, 3 FSMR
- dat_i  in  8  write data
- dat_o  out  8  read data, valid while ack_o=1
- ack_o  out  1  single-cycle acknowledge
- irq  out  1  interrupt request, level
- en_o  out  1  core enable (CSR.E) to downstream
- cmd_valid_o  out  1  command request
- cmd_code_o  out  3  command code
- cmd_data_o  out  8  byte for Write, or bus ID for Set Bus
- cmd_ready_i  in  1  engine accepts the command
- rsp_valid_i  in  1  engine completion pulse
- rsp_code_i  in  2  completion status: 0 DON, 1 NAK, 2 AL, 3 ERR
- rsp_data_i  in  8  received byte, meaningful for Read commands
- bus_busy_i, bus_captured_i  in  1 each  live bus status
- fsm_state_i  in  8  engine state, reflected in FSMR

## Operation
- Bus access
  - cyc_i & stb_i sampled high with ack_o=0 → ack_o=1 on the next cycle, then 0 on the following cycle.
  - Every access costs one wait state.
  - A write takes effect, and read data is latched into dat_o, on the same edge that raises ack_o.
- CSR read = {E, IE, bus_busy_i, bus_captured_i, bus_id[3:0]}.
- CSR write stores E=dat_i[7] and IE=dat_i[6]; other bits are ignored.
- E 1→0 has these effects:
  - FSM forced to IDLE; cmd_valid_o drops.
  - CMDR set to 0x80; irq pending cleared.
  - DPR tx and rx bytes cleared.
- DPR write loads the tx byte; it is ignored unless the FSM is IDLE. DPR read returns the rx byte.
- CMDR read = {DON, NAK, AL, ERR, 1'b0, code[2:0]}. Status is clear while a command is in flight.
- A CMDR read clears irq pending.
- CMDR write is accepted only when E=1 and the FSM is IDLE; otherwise it is ignored, but ack is still given.
- Command codes: 0 Wait, 1 Write, 2 Read+ACK, 3 Read+NAK, 4 Start, 5 Stop, 6 Set Bus, 7 reserved.
- An accepted CMDR write captures code=dat_i[2:0] and cmd_data = tx byte, clears DON/NAK/AL/ERR, then:
  - code 7, or code 6 with tx byte ≥ NUM_BUSES → ERR=1 and pending set on the same edge; no command is issued.
  - all other codes → FSM enters ISSUE.
- FSM
  - IDLE → ISSUE on an accepted CMDR write.
  - ISSUE: cmd_valid_o=1; code and data are stable. cmd_valid_o & cmd_ready_i → WAIT.
  - WAIT: on rsp_valid_i, set the status bit selected by rsp_code_i and set pending, then → IDLE.
    - Read+ACK or Read+NAK completing DON load rx byte ← rsp_data_i.
    - Set Bus completing DON loads bus_id ← cmd_data low 4 bits.
- rsp_valid_i outside WAIT is ignored.
- irq = pending & IE & E.
- FSMR read = fsm_state_i. FSMR writes are ignored.

## Timing
- Reset values:
  - ack_o=0, dat_o=0x00, irq=0, en_o=0.
  - cmd_valid_o=0, cmd_code_o=0, cmd_data_o=0x00.
  - E=IE=0, bus_id=0, CMDR=0x80, tx/rx bytes=0x00, FSM=IDLE.
- Reset asserted mid-cycle or mid-command: all of the above take effect immediately (asynchronous). A pending ack is dropped.
- cmd_valid_o rises on the edge that raises the CMDR write ack. It stays high until the first edge where cmd_ready_i=1.
- Status and pending update on the edge that samples rsp_valid_i. irq rises in the same cycle as that update.
- A CMDR read acked on the same edge as rsp_valid_i:
  - the read returns the old value;
  - set wins, so pending ends up 1.
- A CSR write clearing E on the same edge as rsp_valid_i: the clear wins.
- Back-to-back cycles: a new strobe is sampled only while ack_o=0, so the maximum rate is one access per 2 cycles.

## Test plan
- Reset → read CSR=0x00, CMDR=0x80, FSMR=fsm_state_i. irq=0, cmd_valid_o=0.
- CSR←0xC0; DPR←0x05; CMDR←0x06; engine asserts ready after 3 cycles, then rsp DON →
  - cmd_valid_o held for 3 cycles with code=6, data=0x05;
  - irq=1; CMDR=0x86; CSR[3:0]=5;
  - irq=0 after a CMDR read.
- CMDR←0x02; rsp DON with data 0xA5 → DPR read=0xA5, CMDR=0x82.
- Error paths:
  - CMDR←0x07 → CMDR=0x17 on the ack edge; no cmd_valid_o.
  - DPR←0x10 then CMDR←0x06 with NUM_BUSES=16 → ERR; no cmd_valid_o.
- CMDR←0x01 while in WAIT:
  - the second CMDR write is ignored; its ack is still given;
  - rsp NAK → CMDR=0x41.
- Interrupted command:
  - CSR←0x00 while in WAIT → FSM IDLE, CMDR=0x80; a later rsp_valid_i is ignored.
  - Reset pulse mid-ISSUE → cmd_valid_o=0 immediately.
